// File: rtl/bp_update_scheduler.sv
// Single-write-port scheduler for the predictor tables: clears after reset/flush, then arbitrates
// queued commit updates against fetch-side speculative increments. Stats: BP_SCHED_STATS_EN.
module bp_update_scheduler #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         upd_valid_i,
  input  logic [WIDTH-1:0]             upd_pc_i,
  input  logic                         upd_taken_i,
  output logic                         upd_ready_o,
  input  logic                         spec_req_i,
  input  logic [WIDTH-1:0]             spec_pc_i,
  output logic                         spec_grant_o,
  input  logic                         flush_i,
  output logic                         tbl_we_o,
  output logic [INDEX_W-1:0]           tbl_idx_o,
  output logic [1:0]                   tbl_op_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   pending_o,
  output logic [15:0]                  spec_stall_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [1:0] OpClear      = 2'b00;
  localparam logic [1:0] OpSpecInc    = 2'b01;

  typedef enum logic [1:0] {StRstWait, StClear, StRun} state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] clr_idx_q, clr_idx_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [INDEX_W:0]   mem_q [DEPTH];

  logic full, empty, push, pop, grant;
  logic unused_pc_hi;

  assign unused_pc_hi = ^{upd_pc_i[WIDTH-1:INDEX_W], spec_pc_i[WIDTH-1:INDEX_W]};

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    tbl_we_o    = 1'b0;
    tbl_idx_o   = '0;
    tbl_op_o    = OpClear;
    grant       = 1'b0;
    pop         = 1'b0;
    upd_ready_o = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      StRstWait: state_d = StClear;
      StClear: begin
        tbl_we_o  = 1'b1;
        tbl_idx_o = clr_idx_q;
        clr_idx_d = clr_idx_q + 1'b1;
        if (flush_i) begin
          clr_idx_d = '0;
        end else if (&clr_idx_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        busy_o = 1'b0;
        if (flush_i) begin
          // Flush cycle performs no table write and accepts nothing.
          state_d   = StClear;
          clr_idx_d = '0;
        end else begin
          if (spec_req_i && !full) begin
            grant     = 1'b1;
            tbl_we_o  = 1'b1;
            tbl_op_o  = OpSpecInc;
            tbl_idx_o = spec_pc_i[INDEX_W-1:0];
          end else if (!empty) begin
            pop       = 1'b1;
            tbl_we_o  = 1'b1;
            tbl_op_o  = {1'b1, ~mem_q[rd_ptr_q][0]};
            tbl_idx_o = mem_q[rd_ptr_q][INDEX_W:1];
          end
          upd_ready_o = !full || pop;
        end
      end
      default: state_d = StRstWait;
    endcase
  end

  assign spec_grant_o = grant;
  assign push         = upd_valid_i && upd_ready_o;
  assign pending_o    = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (state_q == StRun && flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRstWait;
      clr_idx_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {upd_pc_i[INDEX_W-1:0], upd_taken_i};
    end
  end

`ifdef BP_SCHED_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StRun && spec_req_i && !grant && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign spec_stall_cnt_o = stall_q;
`else
  assign spec_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed and random steps checked against a queue-based model.
module tb_bp_update_scheduler;

  localparam int Depth = 4;
  localparam int TblSize = 256;

  typedef struct packed {
    logic [7:0] idx;
    logic       t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        spec_req = 1'b0;
  logic [31:0] spec_pc = '0;
  logic        flush = 1'b0;
  logic        upd_ready, spec_grant, tbl_we, busy;
  logic [7:0]  tbl_idx;
  logic [1:0]  tbl_op;
  logic [2:0]  pending;
  logic [15:0] spec_stall_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = waiting after reset, 1 = clearing, 2 = running.
  int   mode;
  int   clr;
  int   stall;
  ent_t q[$];
  logic e_we, e_grant, e_ready, e_busy, e_pop, e_push;
  logic [1:0] e_op;
  logic [7:0] e_idx;

  bp_update_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_taken_i      (upd_taken),
    .upd_ready_o      (upd_ready),
    .spec_req_i       (spec_req),
    .spec_pc_i        (spec_pc),
    .spec_grant_o     (spec_grant),
    .flush_i          (flush),
    .tbl_we_o         (tbl_we),
    .tbl_idx_o        (tbl_idx),
    .tbl_op_o         (tbl_op),
    .busy_o           (busy),
    .pending_o        (pending),
    .spec_stall_cnt_o (spec_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    mode  = 0;
    clr   = 0;
    stall = 0;
    q.delete();
  endtask

  task automatic check_now();
    e_we = 0; e_op = 2'b00; e_idx = '0; e_grant = 0; e_ready = 0; e_busy = 1; e_pop = 0;
    if (rst) begin
      if (mode == 1) begin
        e_we  = 1;
        e_idx = 8'(clr);
      end else if (mode == 2) begin
        e_busy = 0;
        if (!flush) begin
          if (spec_req && q.size() < Depth) begin
            e_grant = 1; e_we = 1; e_op = 2'b01; e_idx = spec_pc[7:0];
          end else if (q.size() > 0) begin
            e_pop = 1; e_we = 1; e_op = {1'b1, ~q[0].t}; e_idx = q[0].idx;
          end
          e_ready = (q.size() < Depth) || e_pop;
        end
      end
    end
    e_push = upd_valid && e_ready;
    chk("tbl_we", 32'(tbl_we), 32'(e_we));
    if (e_we) begin
      chk("tbl_op", 32'(tbl_op), 32'(e_op));
      chk("tbl_idx", 32'(tbl_idx), 32'(e_idx));
    end
    chk("spec_grant", 32'(spec_grant), 32'(e_grant));
    chk("upd_ready", 32'(upd_ready), 32'(e_ready));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("pending", 32'(pending), 32'(q.size()));
`ifdef BP_SCHED_STATS_EN
    chk("spec_stall_cnt", 32'(spec_stall_cnt), 32'(stall));
`else
    chk("spec_stall_cnt", 32'(spec_stall_cnt), 32'd0);
`endif
  endtask

  task automatic update_model();
    if (!rst) return;
    case (mode)
      0: begin mode = 1; clr = 0; end
      1: begin
        if (flush) clr = 0;
        else if (clr == TblSize - 1) begin mode = 2; clr = 0; end
        else clr++;
      end
      default: begin
        if (spec_req && !e_grant && stall < 16'hFFFF) stall++;
        if (flush) begin
          q.delete();
          mode = 1;
          clr  = 0;
        end else begin
          if (e_pop) void'(q.pop_front());
          if (e_push) q.push_back('{idx: upd_pc[7:0], t: upd_taken});
        end
      end
    endcase
  endtask

  task automatic finish_cycle();
    #1;
    check_now();
    @(posedge clk);
    update_model();
  endtask

  task automatic cycle(input logic uv, input logic [31:0] upc, input logic ut,
                       input logic sr, input logic [31:0] spc, input logic fl);
    @(negedge clk);
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    spec_req = sr; spec_pc = spc; flush = fl;
    finish_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1 check_now();
    @(negedge clk);
    check_now();
    @(negedge clk);
    rst = 1'b1;
    finish_cycle();
    idle(TblSize + 2);

    // Three back-to-back commits with no speculative traffic.
    cycle(1, 32'h104, 1, 0, 0, 0);
    cycle(1, 32'h208, 0, 0, 0, 0);
    cycle(1, 32'h30C, 1, 0, 0, 0);
    idle(3);

    // Two queued updates held behind five speculative grants.
    cycle(1, 32'h500, 1, 1, 32'h4F0, 0);
    cycle(1, 32'h611, 0, 1, 32'h4F0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h4F0, 0);
    idle(3);

    // Fill the FIFO with fetch requesting; full FIFO denies spec and drains in order.
    for (int i = 0; i < 14; i++) cycle(1, 32'h700 + 32'(i), i[0], 1, 32'h4F0, 0);
    idle(6);

    // Flush with three pending, then flush again partway through the clear.
    for (int i = 0; i < 3; i++) cycle(1, 32'h800 + 32'(i), 1, 1, 32'h123, 0);
    cycle(0, 0, 0, 0, 0, 1);
    idle(100);
    cycle(0, 0, 0, 0, 0, 1);
    idle(TblSize + 2);

    // Random traffic with rare flushes.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 199) == 0));
    end
    idle(TblSize + 8);

    // Reset mid-drain drops queued work and restarts the clear.
    for (int i = 0; i < 3; i++) cycle(1, 32'h900 + 32'(i), 0, 1, 32'h55, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'hA00 + 32'(i), 1, 1, 32'h66, 0);
    @(negedge clk);
    upd_valid = 0; spec_req = 0; flush = 0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_now();
    @(negedge clk);
    rst = 1'b1;
    finish_cycle();
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
